// File: rtl/mux_scan_sequencer.sv
// Channel-register bank and dwell-timed round-robin select sequencer feeding a 4:1 mux.
// Channels are visited in ascending order through the latched mask, one dwell window each.
module mux_scan_sequencer #(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_en,
    input  logic [1:0]         i_wr_addr,
    input  logic [WIDTH-1:0]   i_wr_data,
    input  logic [3:0]         i_ch_mask,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic               i_single,
    input  logic               i_start,
    input  logic               i_stop,
    output logic [1:0]         o_s,
    output logic [WIDTH-1:0]   o_d0,
    output logic [WIDTH-1:0]   o_d1,
    output logic [WIDTH-1:0]   o_d2,
    output logic [WIDTH-1:0]   o_d3,
    output logic               o_sel_valid,
    output logic               o_sweep_done,
    output logic               o_busy
);

    // state | meaning
    // IDLE  | select held, waiting for start with a non-empty mask
    // SCAN  | stepping select through latched mask, dwell+1 cycles per channel
    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t             r_state;
    logic [1:0]         r_s;
    logic [DWELL_W-1:0] r_cnt;
    logic [3:0]         r_mask;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_single;
    logic               r_done;
    logic [WIDTH-1:0]   r_d [4];

    state_t             w_state_nxt;
    logic [1:0]         w_s_nxt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic               w_done_nxt;
    logic               w_latch;
    logic [1:0]         w_next_ch;

    function automatic logic [1:0] f_lowest(input logic [3:0] mask);
        logic [1:0] ch;
        ch = '0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) ch = 2'(i);
        end
        return ch;
    endfunction

    // Nearest enabled channel above cur, wrapping; returns cur itself for a one-bit mask.
    function automatic logic [1:0] f_next(input logic [1:0] cur, input logic [3:0] mask);
        logic [1:0] ch;
        logic [1:0] idx;
        ch = cur;
        for (int k = 4; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (mask[idx]) ch = idx;
        end
        return ch;
    endfunction

    assign w_next_ch = f_next(r_s, r_mask);

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start && !i_stop && (i_ch_mask != 4'b0000)) begin
                    w_state_nxt = SCAN;
                    w_latch     = 1'b1;
                    w_s_nxt     = f_lowest(i_ch_mask);
                    w_cnt_nxt   = '0;
                end
            end
            SCAN: begin
                if (i_stop) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == r_dwell) begin
                    w_cnt_nxt = '0;
                    // A non-increasing next channel means we are leaving the highest enabled one.
                    if (w_next_ch <= r_s) begin
                        w_done_nxt = 1'b1;
                        if (r_single) w_state_nxt = IDLE;
                        else          w_s_nxt     = w_next_ch;
                    end else begin
                        w_s_nxt = w_next_ch;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DWELL_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_s      <= '0;
            r_cnt    <= '0;
            r_mask   <= '0;
            r_dwell  <= '0;
            r_single <= 1'b0;
            r_done   <= 1'b0;
            for (int i = 0; i < 4; i++) r_d[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            if (w_latch) begin
                r_mask   <= i_ch_mask;
                r_dwell  <= i_dwell;
                r_single <= i_single;
            end
            if (i_wr_en) r_d[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_s          = r_s;
    assign o_busy       = (r_state == SCAN);
    assign o_sel_valid  = (r_state == SCAN);
    assign o_sweep_done = r_done;
    assign o_d0         = r_d[0];
    assign o_d1         = r_d[1];
    assign o_d2         = r_d[2];
    assign o_d3         = r_d[3];

endmodule
